// File: rtl/uart_tx_fifo_reader_pkg.sv
// Purpose: shared UART constants (bit timing, frame width, FSM encodings) for the TX and RX sides.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_tx_fifo_reader_pkg;

    // Bit timing: system clock over line rate, truncated to whole cycles (868 at 100 MHz / 115200).
    localparam int UART_CLK_HZ      = 100_000_000;
    localparam int UART_BAUD        = 115_200;
    localparam int CLKS_PER_BIT_DEF = UART_CLK_HZ / UART_BAUD;

    // Data bits per frame; the TX FIFO entry width matches this.
    localparam int WIDTH_DEF = 8;

    // Serialiser state encodings, shared with the receiver.
    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_START_ENC = 2'd1;
    localparam logic [1:0] ST_DATA_ENC  = 2'd2;
    localparam logic [1:0] ST_STOP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_START = ST_START_ENC,
        ST_DATA  = ST_DATA_ENC,
        ST_STOP  = ST_STOP_ENC
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Purpose: free-running 0..CLKS_PER_BIT-1 bit-period counter with synchronous clear and tick.
// Latency: tick is combinational from the count; a clear takes effect on the next edge.
// Backpressure: none; the counter always runs unless cleared.
module uart_baud_cnt
    import uart_tx_fifo_reader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: clear wins, wrap at the end of a bit period, otherwise advance.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Purpose: pops bytes from a show-ahead TX FIFO and serialises them as 8N1/8N2 frames on tx.
// Latency: tx falls on the edge that ends the pop cycle; a frame is (1+WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: the FIFO is popped only when the line is free (idle, or the last stop-bit cycle), one byte per frame.
module uart_tx_fifo_reader
    import uart_tx_fifo_reader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int STOP_BITS    = 1,
    parameter int WIDTH        = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_ren,
    output logic             tx,
    output logic             busy
);

    localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    uart_state_e      state_q, state_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;

    logic tick;
    logic clr;
    logic last_stop;
    logic pop;

    // The second stop bit (STOP_BITS=2) is the one with stop_idx set; with one stop bit index 0 is last.
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));

    // Pop only when the line is free; gated by reset so nothing is consumed while held in reset.
    assign pop = rst_n & ~fifo_empty &
                 ((state_q == ST_IDLE) | ((state_q == ST_STOP) & tick & last_stop));

    assign fifo_ren = pop;
    assign tx       = tx_q;
    assign busy     = busy_q;

    // Bit-period timer restarts on every state change and is parked at zero while idle.
    assign clr = (state_d != state_q) | (state_q == ST_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    // Frame sequencing: next state, next line level and shift/index updates.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (pop) begin
                    shift_d = fifo_rdata;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d       = 1'b1;
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        if (pop) begin
                            // Next byte already waiting: start bit follows with no idle gap.
                            shift_d = fifo_rdata;
                            tx_d    = 1'b0;
                            state_d = ST_START;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops the in-flight byte and returns the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
        end
    end

endmodule
